// File: rtl/eth_rx_buf_pkg.sv
// Shared types and CSR layout for the Ethernet RX buffer controller.
package eth_rx_buf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    DROP,
    READY,
    DROP_R
  } state_e;

  localparam logic [1:0] CSR_STATUS   = 2'd0;
  localparam logic [1:0] CSR_LEN      = 2'd1;
  localparam logic [1:0] CSR_DROP_CNT = 2'd2;
  localparam logic [1:0] CSR_CONTROL  = 2'd3;

  localparam int unsigned STATUS_READY_BIT  = 0;
  localparam int unsigned STATUS_BUSY_BIT   = 1;
  localparam int unsigned STATUS_IRQ_EN_BIT = 2;

  localparam int unsigned CTRL_RELEASE_BIT = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT  = 1;

endpackage

// File: rtl/eth_rx_buf_csr.sv
// CSR block: register decode, saturating drop counter, registered read mux and irq.
module eth_rx_buf_csr
  import eth_rx_buf_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned LEN_W = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       csr_address,
  input  logic             csr_read,
  input  logic             csr_write,
  input  logic [31:0]      csr_writedata,
  input  logic             ready,
  input  logic             busy,
  input  logic             ready_nxt,
  input  logic [LEN_W-1:0] len,
  input  logic             drop_inc,
  output logic             release_c,
  output logic [31:0]      csr_readdata,
  output logic             irq
);

  logic             irq_en_q, irq_en_d;
  logic             irq_q, irq_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             wr_ctrl, wr_drop;
  logic             unused_wdata;

  assign unused_wdata = ^csr_writedata[31:2];
  assign wr_ctrl      = csr_write && (csr_address == CSR_CONTROL);
  assign wr_drop      = csr_write && (csr_address == CSR_DROP_CNT);

  always_comb begin
    irq_en_d   = irq_en_q;
    drop_cnt_d = drop_cnt_q;
    rdata_d    = '0;
    release_c  = wr_ctrl && csr_writedata[CTRL_RELEASE_BIT] && ready;

    if (wr_ctrl) irq_en_d = csr_writedata[CTRL_IRQ_EN_BIT];

    // A clear that coincides with a new drop leaves that drop counted.
    if (wr_drop) drop_cnt_d = CNT_W'(drop_inc);
    else if (drop_inc && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_W'(1);

    // irq follows the upcoming ownership so it drops on the release edge.
    irq_d = ready_nxt && irq_en_d;

    if (csr_read) begin
      case (csr_address)
        CSR_STATUS: begin
          rdata_d[STATUS_READY_BIT]  = ready;
          rdata_d[STATUS_BUSY_BIT]   = busy;
          rdata_d[STATUS_IRQ_EN_BIT] = irq_en_q;
        end
        CSR_LEN:      rdata_d = 32'(len);
        CSR_DROP_CNT: rdata_d = 32'(drop_cnt_q);
        CSR_CONTROL:  rdata_d[CTRL_IRQ_EN_BIT] = irq_en_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
      drop_cnt_q <= '0;
      rdata_q    <= '0;
    end else begin
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
      drop_cnt_q <= drop_cnt_d;
      rdata_q    <= rdata_d;
    end
  end

  assign csr_readdata = rdata_q;
  assign irq          = irq_q;

endmodule

// File: rtl/eth_rx_buf_ctrl.sv
// RX buffer controller: captures one MAC frame into the single-port RAM and
// hands the port to the CPU until the buffer is released.
module eth_rx_buf_ctrl
  import eth_rx_buf_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_sop,
  input  logic              rx_eop,
  input  logic              rx_err,
  input  logic [1:0]        csr_address,
  input  logic              csr_read,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  input  logic [ADDR_W-1:0] buf_address,
  input  logic              buf_read,
  output logic [7:0]        buf_readdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [7:0]        ram_writedata,
  output logic              ram_clken,
  input  logic [7:0]        ram_readdata,
  output logic              irq
);

  localparam int unsigned PTR_W = ADDR_W + 1;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  len_q, len_d;
  logic              grant_q, grant_d;
  logic              drop_inc_c, release_c, cpu_own_c;
  logic              wr_en_c;
  logic [ADDR_W-1:0] wr_addr_c;
  logic              ready_c, ready_nxt_c, busy_c;

  // Frame capture FSM.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    len_d      = len_q;
    drop_inc_c = 1'b0;
    wr_en_c    = 1'b0;
    wr_addr_c  = wr_ptr_q[ADDR_W-1:0];

    case (state_q)
      IDLE, RECV: begin
        if (rx_valid && rx_sop) begin
          drop_inc_c = (state_q == RECV);
          wr_en_c    = 1'b1;
          wr_addr_c  = '0;
          wr_ptr_d   = PTR_W'(1);
          state_d    = RECV;
          if (rx_eop) begin
            if (rx_err) begin
              drop_inc_c = 1'b1;
              state_d    = IDLE;
            end else begin
              len_d   = PTR_W'(1);
              state_d = READY;
            end
          end
        end else if ((state_q == RECV) && rx_valid) begin
          // Buffer full: never wrap onto byte 0.
          if (wr_ptr_q == PTR_W'(DEPTH)) begin
            drop_inc_c = 1'b1;
            if (rx_eop) state_d = IDLE;
            else        state_d = DROP;
          end else begin
            wr_en_c  = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rx_eop) begin
              if (rx_err) begin
                drop_inc_c = 1'b1;
                state_d    = IDLE;
              end else begin
                len_d   = wr_ptr_q + PTR_W'(1);
                state_d = READY;
              end
            end
          end
        end
      end
      DROP: begin
        if (rx_valid && rx_eop) state_d = IDLE;
      end
      READY: begin
        if (rx_valid && rx_sop) begin
          drop_inc_c = 1'b1;
          if (!rx_eop) state_d = DROP_R;
        end
        if (release_c) state_d = IDLE;
      end
      DROP_R: begin
        if (release_c)                state_d = IDLE;
        else if (rx_valid && rx_eop)  state_d = READY;
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM port ownership mux.
  always_comb begin
    cpu_own_c = (state_q == READY) || (state_q == DROP_R);
    grant_d   = buf_read && cpu_own_c;
    if (cpu_own_c) begin
      ram_address    = buf_address;
      ram_write      = 1'b0;
      ram_chipselect = buf_read;
      ram_writedata  = 8'h00;
    end else begin
      ram_address    = wr_addr_c;
      ram_write      = wr_en_c;
      ram_chipselect = wr_en_c;
      ram_writedata  = wr_en_c ? rx_data : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      len_q    <= '0;
      grant_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      len_q    <= len_d;
      grant_q  <= grant_d;
    end
  end

  assign ready_c      = cpu_own_c;
  assign ready_nxt_c  = (state_d == READY) || (state_d == DROP_R);
  assign busy_c       = (state_q == RECV);
  assign buf_readdata = grant_q ? ram_readdata : 8'h00;
  assign ram_clken    = 1'b1;

  eth_rx_buf_csr #(
    .CNT_W (CNT_W),
    .LEN_W (PTR_W)
  ) u_csr (
    .clk           (clk),
    .reset_n       (reset_n),
    .csr_address   (csr_address),
    .csr_read      (csr_read),
    .csr_write     (csr_write),
    .csr_writedata (csr_writedata),
    .ready         (ready_c),
    .busy          (busy_c),
    .ready_nxt     (ready_nxt_c),
    .len           (len_q),
    .drop_inc      (drop_inc_c),
    .release_c     (release_c),
    .csr_readdata  (csr_readdata),
    .irq           (irq)
  );

endmodule

// File: tb/tb_eth_rx_buf_ctrl.sv
// Scoreboard bench for eth_rx_buf_ctrl with a behavioural 512x8 RAM attached.
module tb_eth_rx_buf_ctrl;
  import eth_rx_buf_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rx_valid, rx_sop, rx_eop, rx_err;
  logic [7:0]  rx_data;
  logic [1:0]  csr_address;
  logic        csr_read, csr_write;
  logic [31:0] csr_writedata, csr_readdata;
  logic [8:0]  buf_address;
  logic        buf_read;
  logic [7:0]  buf_readdata;
  logic [8:0]  ram_address;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [7:0]  ram_writedata, ram_readdata;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;

  logic [31:0] csr_exp_q[$];
  string       csr_tag_q[$];
  logic [31:0] buf_exp_q[$];
  string       buf_tag_q[$];

  logic [7:0]  mem [512];
  logic [8:0]  ram_addr_q = '0;
  logic        csr_rd_d1 = 1'b0;
  logic        buf_rd_d1 = 1'b0;

  always #5 clk = ~clk;

  eth_rx_buf_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_sop(rx_sop), .rx_eop(rx_eop), .rx_err(rx_err),
    .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
    .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
    .buf_address(buf_address), .buf_read(buf_read), .buf_readdata(buf_readdata),
    .ram_address(ram_address), .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_clken(ram_clken), .ram_readdata(ram_readdata),
    .irq(irq)
  );

  // RAM with registered address, combinational q.
  always @(posedge clk) begin
    if (ram_chipselect && ram_write) begin
      mem[ram_address] <= ram_writedata;
      wr_count <= wr_count + 1;
    end
    ram_addr_q <= ram_address;
    csr_rd_d1  <= csr_read;
    buf_rd_d1  <= buf_read;
  end
  assign ram_readdata = mem[ram_addr_q];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (csr_rd_d1) begin
      if (csr_exp_q.size() == 0) check_eq("csr_sb_underflow", 32'(csr_exp_q.size()), 32'd1);
      else check_eq(csr_tag_q.pop_front(), csr_readdata, csr_exp_q.pop_front());
    end
    if (buf_rd_d1) begin
      if (buf_exp_q.size() == 0) check_eq("buf_sb_underflow", 32'(buf_exp_q.size()), 32'd1);
      else check_eq(buf_tag_q.pop_front(), 32'(buf_readdata), buf_exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic sop, input logic eop, input logic err);
    rx_valid = 1'b1; rx_data = d; rx_sop = sop; rx_eop = eop; rx_err = err;
    tick();
    rx_valid = 1'b0; rx_data = 8'h00; rx_sop = 1'b0; rx_eop = 1'b0; rx_err = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [7:0] base, input logic err);
    for (int i = 0; i < n; i++)
      send_byte(8'(int'(base) + i), i == 0, i == n - 1, err && (i == n - 1));
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    csr_address = a; csr_writedata = d; csr_write = 1'b1;
    tick();
    csr_write = 1'b0; csr_writedata = '0;
  endtask

  task automatic csr_rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    csr_exp_q.push_back(exp); csr_tag_q.push_back(tag);
    csr_address = a; csr_read = 1'b1;
    tick();
    csr_read = 1'b0;
  endtask

  task automatic buf_rd(input int a, input logic [7:0] exp, input string tag);
    buf_exp_q.push_back(32'(exp)); buf_tag_q.push_back(tag);
    buf_address = 9'(a); buf_read = 1'b1;
    tick();
    buf_read = 1'b0;
  endtask

  initial begin
    int w0;
    reset_n = 1'b0;
    rx_valid = 1'b0; rx_data = '0; rx_sop = 1'b0; rx_eop = 1'b0; rx_err = 1'b0;
    csr_address = '0; csr_read = 1'b0; csr_write = 1'b0; csr_writedata = '0;
    buf_address = '0; buf_read = 1'b0;
    repeat (3) tick();
    check_eq("rst_irq", 32'(irq), 32'd0);
    check_eq("rst_csr_rdata", csr_readdata, 32'd0);
    check_eq("rst_buf_rdata", 32'(buf_readdata), 32'd0);
    check_eq("rst_ram_write", 32'(ram_write), 32'd0);
    check_eq("ram_clken", 32'(ram_clken), 32'd1);
    reset_n = 1'b1;
    tick();
    csr_rd(CSR_STATUS, 32'h0, "rst_status");
    csr_rd(CSR_LEN, 32'h0, "rst_len");
    csr_rd(CSR_DROP_CNT, 32'h0, "rst_drop");
    csr_rd(CSR_CONTROL, 32'h0, "rst_ctrl");

    // 64-byte good frame
    send_frame(64, 8'h00, 1'b0);
    csr_rd(CSR_STATUS, 32'h1, "f64_status");
    csr_rd(CSR_LEN, 32'd64, "f64_len");
    for (int i = 0; i < 64; i++) buf_rd(i, 8'(i), "f64_data");
    csr_wr(CSR_CONTROL, 32'h1);
    csr_rd(CSR_STATUS, 32'h0, "f64_released");

    // 512-byte frame fits exactly
    send_frame(512, 8'h5A, 1'b0);
    csr_rd(CSR_LEN, 32'd512, "f512_len");
    buf_rd(0, 8'h5A, "f512_first");
    buf_rd(511, 8'(32'h5A + 511), "f512_last");
    csr_wr(CSR_CONTROL, 32'h1);

    // 513-byte frame overflows
    w0 = wr_count;
    send_frame(513, 8'h11, 1'b0);
    check_eq("f513_writes", 32'(wr_count - w0), 32'd512);
    csr_rd(CSR_DROP_CNT, 32'd1, "f513_drop");
    csr_rd(CSR_STATUS, 32'h0, "f513_status");
    csr_wr(CSR_DROP_CNT, 32'h0);
    csr_rd(CSR_DROP_CNT, 32'd0, "drop_clear");

    // errored frame then a good one
    send_frame(20, 8'h40, 1'b1);
    csr_rd(CSR_DROP_CNT, 32'd1, "err_drop");
    csr_rd(CSR_STATUS, 32'h0, "err_status");
    send_frame(10, 8'h80, 1'b0);
    csr_rd(CSR_LEN, 32'd10, "f10_len");
    csr_rd(CSR_STATUS, 32'h1, "f10_status");
    csr_wr(CSR_CONTROL, 32'h1);
    csr_wr(CSR_DROP_CNT, 32'h0);

    // second frame while READY is dropped, buffer preserved
    send_frame(16, 8'hA0, 1'b0);
    send_frame(8, 8'h30, 1'b0);
    csr_rd(CSR_DROP_CNT, 32'd1, "busy_drop");
    csr_rd(CSR_STATUS, 32'h1, "busy_status");
    csr_rd(CSR_LEN, 32'd16, "busy_len");
    for (int i = 0; i < 16; i++) buf_rd(i, 8'(32'hA0 + i), "busy_data");
    // release and sop in the same cycle
    csr_address = CSR_CONTROL; csr_writedata = 32'h1; csr_write = 1'b1;
    rx_valid = 1'b1; rx_sop = 1'b1; rx_data = 8'hEE;
    tick();
    csr_write = 1'b0; csr_writedata = '0;
    rx_valid = 1'b0; rx_sop = 1'b0; rx_data = 8'h00;
    send_byte(8'hE1, 1'b0, 1'b0, 1'b0);
    send_byte(8'hE2, 1'b0, 1'b0, 1'b0);
    send_byte(8'hE3, 1'b0, 1'b1, 1'b0);
    csr_rd(CSR_DROP_CNT, 32'd2, "rel_sop_drop");
    csr_rd(CSR_STATUS, 32'h0, "rel_sop_status");
    csr_wr(CSR_DROP_CNT, 32'h0);

    // irq with a single-byte frame
    csr_wr(CSR_CONTROL, 32'h2);
    csr_rd(CSR_CONTROL, 32'h2, "ctrl_irq_en");
    csr_rd(CSR_STATUS, 32'h4, "status_irq_en");
    check_eq("irq_idle", 32'(irq), 32'd0);
    send_byte(8'h77, 1'b1, 1'b1, 1'b0);
    check_eq("irq_set", 32'(irq), 32'd1);
    csr_rd(CSR_LEN, 32'd1, "f1_len");
    csr_rd(CSR_STATUS, 32'h5, "f1_status");
    buf_rd(0, 8'h77, "f1_data");
    csr_wr(CSR_CONTROL, 32'h3);
    check_eq("irq_clr", 32'(irq), 32'd0);
    buf_rd(0, 8'h00, "buf_idle");

    // reset mid-frame
    for (int i = 0; i < 5; i++) send_byte(8'(i + 8'hC0), i == 0, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    tick();
    check_eq("mid_rst_irq", 32'(irq), 32'd0);
    check_eq("mid_rst_rdata", csr_readdata, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    csr_rd(CSR_STATUS, 32'h0, "post_rst_status");
    csr_rd(CSR_LEN, 32'h0, "post_rst_len");
    csr_rd(CSR_DROP_CNT, 32'h0, "post_rst_drop");
    csr_rd(CSR_CONTROL, 32'h0, "post_rst_ctrl");
    send_frame(12, 8'h20, 1'b0);
    csr_rd(CSR_STATUS, 32'h1, "f12_status");
    csr_rd(CSR_LEN, 32'd12, "f12_len");
    for (int i = 0; i < 12; i++) buf_rd(i, 8'(32'h20 + i), "f12_data");

    repeat (3) tick();
    check_eq("sb_drain", 32'(csr_exp_q.size() + buf_exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
